// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
// Holds the FSM encoding, the mode encoding and the parameter sanity check.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // True when DIGIT is usable for WIDTH: 1..WIDTH and an exact divisor.
    function automatic bit width_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder built from full_adder cells.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[DIGIT];

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the digit ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract engine with valid/ready on both sides.
// Subtraction is a + ~b + 1; the flag is true carry (add) or true borrow (sub).
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGIT    = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (!width_ok(WIDTH, DIGIT)) begin : g_param_err
        $error("serial_addsub: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               mode_q, mode_d;
    logic               flag_q, flag_d;

    logic [DIGIT-1:0]   dig_sum;
    logic               dig_cout;
    logic               raw_flag;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a   (a_q[DIGIT-1:0]),
        .b   (b_q[DIGIT-1:0]),
        .cin (carry_q),
        .sum (dig_sum),
        .cout(dig_cout)
    );

    // A subtraction without final carry-out means a < b.
    assign raw_flag = (mode_q == MODE_SUB) ? ~dig_cout : dig_cout;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        flag_d  = flag_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = (mode == MODE_SUB) ? ~b : b;
                    mode_d  = mode;
                    carry_d = mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    flag_d  = raw_flag;
                    if (SATURATE != 0 && raw_flag) begin
                        res_d = (mode_q == MODE_SUB) ? '0 : '1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the values from before this edge.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            flag_q  <= flag_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign flag      = flag_q;

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle add/subtract unit for the vending-machine datapath. It replaces the fixed 4-bit ripple subtractor with a WIDTH-bit digit-serial engine that computes credit − price (or credit + coin) DIGIT bits per cycle. It reports a true borrow/carry flag and can optionally saturate. It sits between the credit register and the change/dispense controller and uses a valid/ready handshake on both sides.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle, 1..WIDTH; N = WIDTH/DIGIT iterations.
- SATURATE, 0, 1 = clamp on overflow/underflow; 0 = wrap modulo 2^WIDTH.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  unit idle and able to accept.
- a  input  WIDTH  first operand (credit / minuend).
- b  input  WIDTH  second operand (price, coin / subtrahend).
- mode  input  1  0 = a+b, 1 = a−b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  sum or difference, wrapped or clamped.
- flag  output  1  add: carry-out; sub: borrow (1 iff a < b, unsigned).

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. When in_valid=1 at an edge:
  - capture a;
  - capture b, inverted if mode=1;
  - capture mode;
  - set the carry register to mode (two's-complement +1);
  - set the iteration counter to 0;
  - go to RUN.
- RUN: in_ready=0, out_valid=0. Each cycle:
  - add the low DIGIT bits of the a and b shift registers plus the carry register;
  - shift the DIGIT sum bits into the top of the result shift register; shift a and b right by DIGIT;
  - update the carry register;
  - increment the counter.
  - After N iterations → DONE.
- DONE: out_valid=1; result and flag are stable.
  - Raw flag: add → final carry; sub → inverted final carry (true borrow).
  - SATURATE=1: add with carry → result = all-ones; sub with borrow → result = 0. The flag is still reported.
  - SATURATE=0: result is the wrapped WIDTH-bit value.
  - When out_ready=1 at an edge → IDLE.
- in_valid is ignored outside IDLE. Operand inputs are don't-care outside the accepting edge.
- out_ready is ignored outside DONE.
- Asynchronous reset in any state (including mid-RUN):
  - FSM → IDLE; all shift registers, counter, carry and flag → 0;
  - the partial transaction is discarded with no output.
- Reset values: in_ready=1, out_valid=0, result=0, flag=0.

## Timing
- Acceptance at edge E0. RUN covers edges E1..EN. out_valid rises after edge EN.
- Latency: N cycles from acceptance to out_valid.
- DONE → IDLE on the handshake edge. The next acceptance can happen at the following edge.
- Minimum period: N+2 cycles per transaction with out_ready held at 1.
- Back-pressure: out_valid, result and flag hold indefinitely while out_ready=0.
- All outputs are registered or decoded directly from state. There is no combinational path from in_valid or out_ready to any output.
- DIGIT=WIDTH degenerates to a single RUN cycle; the behaviour must be otherwise identical.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - MODE_ADD=0 and MODE_SUB=1;
  - a compile-time check function that WIDTH % DIGIT == 0.
- One sub-module, digit_adder: a DIGIT-bit ripple chain built from the existing full_adder cell (carry in, DIGIT sum bits, carry out). serial_addsub instantiates it once.
- The counter width is clog2(N+1).

## Test plan
- WIDTH=8, DIGIT=2, SAT=0: sub a=0x2D, b=0x0F → out_valid 4 cycles after acceptance, result=0x1E, flag=0.
- Same config: sub a=0x05, b=0x0A → result=0xFB, flag=1. Rerun with SAT=1 → result=0x00, flag=1.
- Add a=0xF0, b=0x20 → SAT=0: result=0x10, flag=1. SAT=1: result=0xFF, flag=1.
- Hold out_ready=0 for 5 cycles in DONE → result/flag stable, in_ready=0. Pulse in_valid with new operands during RUN and DONE → ignored, first result unchanged.
- Assert rst_n=0 at the 2nd RUN cycle → immediately in_ready=1, out_valid=0, result=0. The next transaction 0x07−0x03 → 0x04, flag=0.
- Randomised sweep for DIGIT ∈ {1,2,4,8}, WIDTH=8, both modes → matches the reference model for result/flag. Throughput is exactly N+2 cycles with out_ready=1.
